// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect/halt
// controls from execute, and the decoded-head handshake toward decode.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  opcode;
    logic [5:0]  func;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc, halt,
        output inst_valid, inst, inst_pc, opcode, func,
        input  inst_ready
    );

    // Memory / control / decode side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc, halt,
        input  inst_valid, inst, inst_pc, opcode, func,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, keeps one word read in flight, buffers
// returned words in a shift-register FIFO whose entry 0 is the decode head.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic           clk,
    input logic           rst_b,
    ifetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic            busy_q, busy_d;
    logic            drop_q, drop_d;
    logic            valid_q, valid_d;

    logic            pop, ack, push, issue;
    logic [CW-1:0]   count_mid, count_after;

    // Next-state: FIFO shift/push, PC advance, issue with response credit, redirect flush
    always_comb begin
        pop         = valid_q && bus.inst_ready;
        ack         = busy_q && bus.imem_ack;
        push        = ack && !drop_q && !bus.redirect;
        count_mid   = count_q - CW'(pop);
        count_after = count_mid + CW'(push);

        for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                fifo_d[i] = fifo_q[i + 1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push && (CW'(i) == count_mid)) begin
                fifo_d[i] = '{word: bus.imem_rdata, pc: addr_q};
            end
        end

        fetch_pc_d = push ? (addr_q + 32'd4) : fetch_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end

        // A dropped ack frees the port but the restart waits one edge
        issue = (!busy_q || (bus.imem_ack && !drop_q)) && !bus.halt && !bus.redirect
                && (count_after < CW'(DEPTH));

        addr_d = issue ? fetch_pc_d : addr_q;

        busy_d = busy_q;
        if (issue) begin
            busy_d = 1'b1;
        end else if (ack) begin
            busy_d = 1'b0;
        end

        drop_d = drop_q;
        if (ack) begin
            drop_d = 1'b0;
        end else if (bus.redirect && busy_q) begin
            drop_d = 1'b1;
        end

        count_d = bus.redirect ? '0 : count_after;
        valid_d = !bus.redirect && (count_after != '0);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.imem_req   = busy_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = fifo_q[0].word;
    assign bus.inst_pc    = fifo_q[0].pc;
    assign bus.opcode     = fifo_q[0].word[31:26];
    assign bus.func       = fifo_q[0].word[5:0];
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: variable-latency memory responder, queue-based
// reference of the fetch stream, per-cycle compare plus directed pins.
module tb_ifetch_unit;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc, m_addr;
    bit          m_busy, m_drop;

    int vectors = 0;
    int miscompares = 0;
    int mem_cnt, mem_lat;
    int lat_mode = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_lat();
        mem_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc   = RESET_PC;
        m_addr  = RESET_PC;
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        mem_cnt = 0;
        new_lat();
    endtask

    // Reference fetch behaviour for one clock edge, from the stage's stated rules
    task automatic model_step(input bit ready, input bit redir, input logic [31:0] rpc,
                              input bit hlt, input bit ack_in, input logic [31:0] rdata);
        bit   acc, pop, was_drop;
        ent_t e;
        acc      = m_busy && ack_in;
        pop      = (mq.size() != 0) && ready;
        was_drop = m_drop;
        if (redir) begin
            mq.delete();
            m_fpc = rpc & 32'hFFFF_FFFC;
            if (acc) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else if (m_busy) begin
                m_drop = 1'b1;
            end
            return;
        end
        if (pop) void'(mq.pop_front());
        if (acc) begin
            if (!was_drop) begin
                e.w  = rdata;
                e.pc = m_addr;
                mq.push_back(e);
                m_fpc = m_addr + 32'd4;
            end
            m_busy = 1'b0;
            m_drop = 1'b0;
        end
        if (!m_busy && !(acc && was_drop) && !hlt && mq.size() < DEPTH) begin
            m_busy = 1'b1;
            m_addr = m_fpc;
        end
    endtask

    task automatic compare_all();
        ent_t h;
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_busy});
        chk("imem_addr", bus.imem_addr, m_addr);
        chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            h = mq[0];
            chk("inst", bus.inst, h.w);
            chk("inst_pc", bus.inst_pc, h.pc);
            chk("opcode", {26'b0, bus.opcode}, {26'b0, h.w[31:26]});
            chk("func", {26'b0, bus.func}, {26'b0, h.w[5:0]});
        end
    endtask

    // One clock: starts at a negedge, drives inputs, steps model at posedge, compares
    task automatic cycle(input bit ready, input bit redir, input logic [31:0] rpc, input bit hlt);
        bit          ack, req;
        logic [31:0] rdata;
        req = bus.imem_req;
        ack = req && (mem_cnt >= mem_lat);
        rdata = ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
        bus.inst_ready  = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.halt        = hlt;
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        @(posedge clk);
        model_step(ready, redir, rpc, hlt, ack, rdata);
        if (ack) begin
            mem_cnt = 0;
            new_lat();
        end else if (req) begin
            mem_cnt++;
        end
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse, entered and left at a negedge
    task automatic do_reset();
        rst_b = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.halt = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        #1;
        chk("rst_req_now", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid_now", {31'b0, bus.inst_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_opfunc", {20'b0, bus.opcode, bus.func}, 32'd0);
        rst_b = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        bit          found, saw0, hlt;

        bus.inst_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.halt = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        model_reset();
        @(negedge clk);

        // Zero-wait memory, decode always ready
        lat_mode = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, '0, 1'b0);
            chk("p1_addr", bus.imem_addr, 32'(4 * k));
            if (k > 0) begin
                w = mem_word(32'(4 * (k - 1)));
                chk("p1_inst_pc", bus.inst_pc, 32'(4 * (k - 1)));
                chk("p1_opcode", {26'b0, bus.opcode}, {26'b0, w[31:26]});
                chk("p1_func", {26'b0, bus.func}, {26'b0, w[5:0]});
            end
        end

        // Decode stalled: FIFO fills to DEPTH, request stops, resumes on first pop
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, '0, 1'b0);
        chk("p2_req_low", {31'b0, bus.imem_req}, 32'd0);
        chk("p2_valid", {31'b0, bus.inst_valid}, 32'd1);
        chk("p2_head", bus.inst_pc, 32'h0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("p2_resume_addr", bus.imem_addr, 32'h8);
        chk("p2_next_head", bus.inst_pc, 32'h4);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, '0, 1'b0);

        // Async reset with a full FIFO, then restart at RESET_PC
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b0);
        chk("p6_full", {31'b0, bus.inst_valid}, 32'd1);
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("p6_first_addr", bus.imem_addr, RESET_PC);

        // 3-cycle memory, redirect while 0x8 is outstanding
        lat_mode = 3;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (bus.imem_req && bus.imem_addr == 32'h8 && mem_cnt == 0) found = 1'b1;
            else cycle(1'b1, 1'b0, '0, 1'b0);
        end
        chk("p3_reach_8", {31'b0, found}, 32'd1);
        cycle(1'b1, 1'b1, 32'h0000_0103, 1'b0);
        chk("p3_flushed", {31'b0, bus.inst_valid}, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus.imem_req && bus.imem_addr != 32'h8) found = 1'b1;
            else cycle(1'b1, 1'b0, '0, 1'b0);
        end
        chk("p3_target_addr", bus.imem_addr, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus.inst_valid) found = 1'b1;
            else cycle(1'b1, 1'b0, '0, 1'b0);
        end
        chk("p3_first_pc", bus.inst_pc, 32'h100);

        // Redirect coinciding with ack of 0x4 and pop of 0x0
        lat_mode = 0;
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("p4_head0", bus.inst_pc, 32'h0);
        chk("p4_out4", bus.imem_addr, 32'h4);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("p4_empty", {31'b0, bus.inst_valid}, 32'd0);
        chk("p4_no_req", {31'b0, bus.imem_req}, 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("p4_req_target", bus.imem_addr, 32'h200);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("p4_head_target", bus.inst_pc, 32'h200);

        // Halt with one request outstanding
        lat_mode = 2;
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        saw0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            if (bus.inst_valid && bus.inst_pc == 32'h0) saw0 = 1'b1;
        end
        chk("p5_delivered", {31'b0, saw0}, 32'd1);
        chk("p5_halted", {31'b0, bus.imem_req}, 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("p5_resume_req", {31'b0, bus.imem_req}, 32'd1);
        chk("p5_resume_addr", bus.imem_addr, 32'h4);

        // PC wrap at the top of the address space
        lat_mode = 0;
        do_reset();
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("wrap_zero", bus.imem_addr, 32'h0);
        chk("wrap_head", bus.inst_pc, 32'hFFFF_FFFC);

        // Randomized traffic: latency, stalls, redirects, halt bursts
        lat_mode = -1;
        do_reset();
        hlt = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) hlt = ~hlt;
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), $urandom, hlt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
